// File: rtl/booth_r4_seq_mac_ctrl.sv
// booth_r4_seq_mac_ctrl
//   Sequential radix-4 Booth multiplier controller. One Booth digit is encoded
//   per cycle. Its partial product (0, +-A, +-2A, shifted by 2*digit index) is
//   accumulated into a 2*WIDTH register through a single shared adder.
//   Operands come in through a valid/ready intake. The product leaves through
//   a valid/ready delivery port.
//
// Optional feature macro: BOOTH_ZERO_SKIP_EN
//   When defined, a zero Booth digit does not write the accumulator. The
//   operation also finishes early once every remaining digit is zero.
//   When undefined, every digit is added (zeros included) and latency is
//   fixed at NDIG cycles.
//   Product and nz_cnt are identical in both builds.
//
// Ports
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous active-high reset
//   in_valid   in   1              operand pair valid
//   in_ready   out  1              controller can accept operands (IDLE, not in reset)
//   a_in       in   WIDTH          multiplicand, signed
//   b_in       in   WIDTH          multiplier, signed, Booth-encoded
//   out_valid  out  1              product valid (DONE)
//   out_ready  in   1              sink accepts product
//   product    out  2*WIDTH        signed product a*b, updated only on DONE entry
//   busy       out  1              high while in CALC
//   nz_cnt     out  clog2(NDIG+1)  nonzero Booth digits of the last/current operation

module booth_r4_seq_mac_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 a_in,
  input  logic [WIDTH-1:0]                 b_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2*WIDTH-1:0]               product,
  output logic                             busy,
  output logic [$clog2(WIDTH/2+1)-1:0]     nz_cnt
);

  localparam int NDIG  = WIDTH / 2;
  localparam int OUT_W = 2 * WIDTH;
  localparam int IDX_W = $clog2(NDIG);
  localparam int CNT_W = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [OUT_W-1:0]     a_r;        // multiplicand, sign-extended to product width
  logic [WIDTH:0]       b_r;        // {multiplier, 1'b0}; bit 0 is the implicit b[-1]
  logic [OUT_W-1:0]     acc_r;
  logic [IDX_W-1:0]     idx_r;
  logic [CNT_W-1:0]     nz_cnt_r;
  logic [OUT_W-1:0]     product_r;

  logic [2:0]           trip_s;
  logic                 nz_s;
  logic [OUT_W-1:0]     mag_s;
  logic                 neg_s;
  logic [OUT_W-1:0]     pp_s;
  logic [OUT_W-1:0]     sum_s;
  logic                 last_s;
  logic                 acc_we_s;

  // Booth triplet {b[2k+1], b[2k], b[2k-1]} for digit k
  function automatic logic [2:0] triplet_f(input logic [WIDTH:0] b, input int k);
    logic [WIDTH:0] t;
    t = b >> (2 * k);
    return t[2:0];
  endfunction

  // A digit is zero exactly for triplets 000 and 111
  function automatic logic digit_nz_f(input logic [2:0] t);
    return (t != 3'b000) && (t != 3'b111);
  endfunction

  assign in_ready  = (state_r == S_IDLE) && !rst;
  assign busy      = (state_r == S_CALC);
  assign out_valid = (state_r == S_DONE);
  assign product   = product_r;
  assign nz_cnt    = nz_cnt_r;

  // Booth decode of the current digit into magnitude and sign
  always_comb begin
    trip_s = triplet_f(b_r, int'(idx_r));
    nz_s   = digit_nz_f(trip_s);
    mag_s  = {OUT_W{1'b0}};
    neg_s  = 1'b0;
    case (trip_s)
      3'b001, 3'b010: begin mag_s = a_r;        neg_s = 1'b0; end
      3'b011:         begin mag_s = a_r << 1;   neg_s = 1'b0; end
      3'b100:         begin mag_s = a_r << 1;   neg_s = 1'b1; end
      3'b101, 3'b110: begin mag_s = a_r;        neg_s = 1'b1; end
      default:        begin mag_s = {OUT_W{1'b0}}; neg_s = 1'b0; end
    endcase
  end

  // Shifted partial product and the single shared adder (mod 2^OUT_W)
  always_comb begin
    if (neg_s) begin
      pp_s = (~mag_s) + {{(OUT_W-1){1'b0}}, 1'b1};
    end else begin
      pp_s = mag_s;
    end
    pp_s  = pp_s << {idx_r, 1'b0};
    sum_s = acc_r + pp_s;
  end

`ifdef BOOTH_ZERO_SKIP_EN
  logic rest_zero_s;

  // True when every digit above the current index is zero
  always_comb begin
    rest_zero_s = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if ((k > int'(idx_r)) && digit_nz_f(triplet_f(b_r, k))) begin
        rest_zero_s = 1'b0;
      end else begin
        rest_zero_s = rest_zero_s;
      end
    end
  end

  // Zero digits hold the accumulator; finish once the remaining digits are zero
  always_comb begin
    acc_we_s = nz_s;
    last_s   = (idx_r == IDX_W'(NDIG - 1)) || rest_zero_s;
  end
`else
  // Every digit writes the accumulator; fixed NDIG-cycle latency
  always_comb begin
    acc_we_s = 1'b1;
    last_s   = (idx_r == IDX_W'(NDIG - 1));
  end
`endif

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          state_s = S_CALC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_CALC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: operand capture, per-digit accumulate, product capture on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= {OUT_W{1'b0}};
      b_r       <= {(WIDTH+1){1'b0}};
      acc_r     <= {OUT_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      nz_cnt_r  <= {CNT_W{1'b0}};
      product_r <= {OUT_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            a_r      <= {{WIDTH{a_in[WIDTH-1]}}, a_in};
            b_r      <= {b_in, 1'b0};
            acc_r    <= {OUT_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            nz_cnt_r <= {CNT_W{1'b0}};
          end else begin
            acc_r <= acc_r;
          end
        end
        S_CALC: begin
          if (acc_we_s) begin
            acc_r <= sum_s;
          end else begin
            acc_r <= acc_r;
          end
          if (nz_s) begin
            nz_cnt_r <= nz_cnt_r + CNT_W'(1);
          end else begin
            nz_cnt_r <= nz_cnt_r;
          end
          if (last_s) begin
            product_r <= acc_we_s ? sum_s : acc_r;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        S_DONE: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mac_ctrl.sv
module tb_booth_r4_seq_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [2:0]  nz_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc1 = 0;
  int acc2 = 0;

`ifdef BOOTH_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  booth_r4_seq_mac_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .nz_cnt    (nz_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, wait for DONE, optional stall, handshake
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ep, input logic [2:0] en, input int lat,
                        input int hold, input bit junk);
    int n;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = 1'b0;
    @(posedge clk); #1;
    acc_cyc = cyc;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (junk) begin
      a_in = 8'h5A;
      b_in = 8'hA5;
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_product"}, 32'(product), 32'(ep));
    chk({tag, "_nz_cnt"}, 32'(nz_cnt), 32'(en));
    chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_product"}, 32'(product), 32'(ep));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_post_product"}, 32'(product), 32'(ep));
    chk({tag, "_post_nz_cnt"}, 32'(nz_cnt), 32'(en));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = 8'h00;
    b_in      = 8'h00;
    out_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_nz_cnt", 32'(nz_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);

    // 1: 7 * -3, digits +1,-1,0,0
    run_op("t1", 8'd7, 8'hFD, 16'hFFEB, 3'd2, SKIP ? 2 : 4, 0, 1'b0);
    // 4: 55 * 0, all digits zero
    run_op("t4", 8'd55, 8'h00, 16'h0000, 3'd0, SKIP ? 1 : 4, 0, 1'b0);
    // 2: -128 * -128, digits 0,0,0,-2
    run_op("t2", 8'h80, 8'h80, 16'h4000, 3'd1, 4, 0, 1'b0);
    // 3: back-to-back with in_valid kept high (junk operands must be ignored)
    run_op("t3a", 8'd127, 8'd127, 16'h3F01, 3'd2, 4, 0, 1'b1);
    acc1 = acc_cyc;
    run_op("t3b", 8'hFF, 8'h01, 16'hFFFF, 3'd1, SKIP ? 1 : 4, 0, 1'b1);
    acc2 = acc_cyc;
    chk("t3_interval", 32'((acc2 - acc1) >= 6), 32'd1);
    // 5: stall in DONE for 10 cycles; 12 * -7
    run_op("t5", 8'd12, 8'hF9, 16'hFFAC, 3'd2, SKIP ? 2 : 4, 10, 1'b0);

    // 6: reset during the second CALC cycle
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 8'd7;
    b_in     = 8'hFD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t6_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_product", 32'(product), 32'd0);
    chk("t6_busy_rst", 32'(busy), 32'd0);
    chk("t6_nz_cnt", 32'(nz_cnt), 32'd0);
    chk("t6_in_ready_rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_no_valid", 32'(out_valid), 32'd0);
    run_op("t6b", 8'hFB, 8'd6, 16'hFFE2, 3'd2, SKIP ? 2 : 4, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
